// File: rtl/uart_pkg.sv
// Shared UART constants: feeder FSM encoding, default register offsets and
// the tx_ready bit position, used by the feeder, the UART regs and the benches.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    POLL_SETUP  = 3'd1,
    POLL_ACCESS = 3'd2,
    WR_SETUP    = 3'd3,
    WR_ACCESS   = 3'd4,
    GAP         = 3'd5
  } feeder_state_t;

  localparam logic [4:0] UART_STATUS_ADDR  = 5'h04;
  localparam logic [4:0] UART_TX_DATA_ADDR = 5'h00;
  localparam int         UART_TX_READY_BIT = 0;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with show-ahead head output; pointers carry one extra
// wrap bit so full/empty/level fall out of plain pointer arithmetic.
module uart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // Same slot index but different wrap bit means the writer lapped the reader.
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_apb_tx_feeder.sv
// APB master that drains a byte FIFO into the UART TX data register, polling
// status for tx_ready first. Optional PSLVERR counter: UART_FEEDER_ERR_CNT_EN.
module uart_apb_tx_feeder
  import uart_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [4:0] STATUS_ADDR  = UART_STATUS_ADDR,
  parameter logic [4:0] TX_DATA_ADDR = UART_TX_DATA_ADDR,
  parameter int         TX_READY_BIT = UART_TX_READY_BIT,
  parameter int         POLL_GAP     = 4
) (
  input  logic                          PCLK,
  input  logic                          PRESETN,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic [4:0]                    PADDR,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [7:0]                    PWDATA,
  input  logic [7:0]                    PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    err_cnt
);

  feeder_state_t state;
  feeder_state_t state_nxt;
  logic [7:0]    gap_cnt;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          unused_prdata;

  assign unused_prdata = ^PRDATA;
  assign in_ready      = !full;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETN),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:        if (!empty) state_nxt = POLL_SETUP;
      POLL_SETUP:  state_nxt = POLL_ACCESS;
      POLL_ACCESS: if (PREADY) state_nxt = (!PSLVERR && PRDATA[TX_READY_BIT]) ? WR_SETUP : GAP;
      WR_SETUP:    state_nxt = WR_ACCESS;
      // The byte leaves the FIFO on completion even when the slave flags an error.
      WR_ACCESS: begin
        if (PREADY) begin
          pop       = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:         if (gap_cnt == 8'd0) state_nxt = empty ? IDLE : POLL_SETUP;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state   <= IDLE;
      gap_cnt <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      state   <= state_nxt;
      PSEL    <= state_nxt inside {POLL_SETUP, POLL_ACCESS, WR_SETUP, WR_ACCESS};
      PENABLE <= state_nxt inside {POLL_ACCESS, WR_ACCESS};
      if (state_nxt == GAP && state != GAP)
        gap_cnt <= 8'(POLL_GAP - 1);
      else if (state == GAP && gap_cnt != 8'd0)
        gap_cnt <= gap_cnt - 8'd1;
      // Address/data only change when a new SETUP begins, so they hold through ACCESS and idle.
      if (state_nxt == POLL_SETUP) begin
        PADDR  <= STATUS_ADDR;
        PWRITE <= 1'b0;
      end
      if (state_nxt == WR_SETUP) begin
        PADDR  <= TX_DATA_ADDR;
        PWRITE <= 1'b1;
        PWDATA <= head;
      end
    end
  end

`ifdef UART_FEEDER_ERR_CNT_EN
  logic err_hit;
  assign err_hit = (state == POLL_ACCESS || state == WR_ACCESS) && PREADY && PSLVERR;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)
      err_cnt <= '0;
    else if (err_hit && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_apb_tx_feeder.sv
// Bench for uart_apb_tx_feeder: reactive APB UART slave, push-order scoreboard,
// table-driven fill test and hand-written wait-state, error and reset sequences.
module tb_uart_apb_tx_feeder;

  localparam int POLL_GAP = 4;
`ifdef UART_FEEDER_ERR_CNT_EN
  localparam bit ERR_CNT_ON = 1'b1;
`else
  localparam bit ERR_CNT_ON = 1'b0;
`endif

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [4:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic [3:0] fifo_level;
  logic [7:0] err_cnt;

  always #5 PCLK = ~PCLK;

  uart_apb_tx_feeder #(.FIFO_DEPTH(8), .POLL_GAP(POLL_GAP)) dut (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .fifo_level (fifo_level),
    .err_cnt    (err_cnt)
  );

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART slave model knobs and logs
  int         wr_wait   = 0;
  int         poll_wait = 0;
  int         tx_mode   = 1;   // 0 never ready, 1 always ready, 2 random
  bit         err_en    = 1'b0;
  logic [7:0] err_byte  = 8'h00;
  int         exp_err   = 0;
  logic [7:0] wr_q[$];
  int         poll_cyc[$];
  logic [7:0] exp_q[$];

  initial begin : slave
    int         wait_left;
    int         cfg;
    logic [4:0] s_addr;
    logic       s_write;
    logic [7:0] s_wdata;
    logic       rdy;
    wait_left = 0;
    s_addr = '0; s_write = 1'b0; s_wdata = '0;
    PREADY = 1'b0; PRDATA = 8'h00; PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      if (PSEL && !PENABLE) begin
        s_addr  = PADDR;
        s_write = PWRITE;
        s_wdata = PWDATA;
        if (!PWRITE) poll_cyc.push_back(cyc);
        cfg = PWRITE ? wr_wait : poll_wait;
        wait_left = (cfg < 0) ? int'($urandom_range(3, 0)) : cfg;
        check("setup_addr", 32'(PADDR), PWRITE ? 32'h00 : 32'h04);
      end else if (PSEL && PENABLE) begin
        check("hold_addr", 32'(PADDR), 32'(s_addr));
        check("hold_write", 32'(PWRITE), 32'(s_write));
        if (s_write) check("hold_wdata", 32'(PWDATA), 32'(s_wdata));
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          PREADY = 1'b1;
          if (PWRITE) begin
            wr_q.push_back(PWDATA);
            if (err_en && PWDATA == err_byte) begin
              PSLVERR = 1'b1;
              exp_err++;
            end
          end else begin
            rdy = (tx_mode == 2) ? 1'($urandom_range(1, 0)) : (tx_mode == 1);
            PRDATA = {7'($urandom), rdy};
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d, output bit acc);
    @(negedge PCLK);
    in_valid = 1'b1;
    in_data  = d;
    acc      = in_ready;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic stream_byte(input logic [7:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      push_byte(d, acc);
      n++;
    end
    check("stream_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle_in();
    @(negedge PCLK);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge PCLK);
      if (fifo_level == 4'd0 && !PSEL) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  task automatic wait_wr_access(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE && PWRITE) begin
        seen = 1'b1;
        break;
      end
    end
    check("wr_access_seen", 32'(seen), 32'd1);
  endtask

  task automatic compare_writes(input string name);
    int n;
    check({name, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_byte"}, 32'(wr_q[i]), 32'(exp_q[i]));
    wr_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0] d;
    bit         acc;
    logic [3:0] lvl;
    bit         rdy;
  } fill_vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    fill_vec_t tbl[9];
    bit        acc;

    for (int i = 0; i < 9; i++) begin
      tbl[i].d   = 8'(16 + i);
      tbl[i].acc = (i < 8);
      tbl[i].lvl = (i < 8) ? 4'(i + 1) : 4'd8;
      tbl[i].rdy = (i + 1 < 8);
    end

    in_valid = 1'b0;
    in_data  = 8'h00;
    PRESETN  = 1'b0;
    repeat (2) @(negedge PCLK);
    check("rst_psel", 32'(PSEL), 0);
    check("rst_penable", 32'(PENABLE), 0);
    check("rst_pwrite", 32'(PWRITE), 0);
    check("rst_paddr", 32'(PADDR), 0);
    check("rst_pwdata", 32'(PWDATA), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    PRESETN = 1'b1;
    repeat (2) @(negedge PCLK);

    // Single byte, PSEL timing after first push
    tx_mode = 1; wr_wait = 0; poll_wait = 0;
    poll_cyc.delete();
    push_byte(8'h55, acc);
    @(negedge PCLK);
    in_valid = 1'b0;
    check("single_level1", 32'(fifo_level), 1);
    check("single_psel_idle", 32'(PSEL), 0);
    @(negedge PCLK);
    check("single_psel", 32'(PSEL), 1);
    check("single_penable", 32'(PENABLE), 0);
    check("single_paddr", 32'(PADDR), 32'h04);
    check("single_pwrite", 32'(PWRITE), 0);
    wait_drain(50);
    check("single_level0", 32'(fifo_level), 0);
    check("single_polls", 32'(poll_cyc.size()), 1);
    compare_writes("single");
    repeat (8) @(negedge PCLK);

    // Fill to full with tx_ready low
    tx_mode = 0;
    poll_cyc.delete();
    for (int i = 0; i < 9; i++) begin
      @(negedge PCLK);
      in_valid = 1'b1;
      in_data  = tbl[i].d;
      check("full_accept", 32'(in_ready), 32'(tbl[i].acc));
      if (in_ready) exp_q.push_back(tbl[i].d);
      @(posedge PCLK);
      #1;
      check("full_level", 32'(fifo_level), 32'(tbl[i].lvl));
      check("full_in_ready", 32'(in_ready), 32'(tbl[i].rdy));
    end
    idle_in();
    repeat (30) @(negedge PCLK);
    check("full_no_writes", 32'(wr_q.size()), 0);
    check("full_poll_seen", 32'(poll_cyc.size() >= 4), 1);
    for (int k = 1; k < poll_cyc.size(); k++)
      check("full_poll_period", 32'(poll_cyc[k] - poll_cyc[k-1]), 32'(POLL_GAP + 2));
    tx_mode = 1;
    wait_drain(300);
    compare_writes("full");
    repeat (8) @(negedge PCLK);

    // Write wait states
    wr_wait = 3;
    push_byte(8'h3C, acc);
    idle_in();
    wait_wr_access(50);
    for (int k = 0; k < 4; k++) begin
      check("ws_psel", 32'(PSEL), 1);
      check("ws_penable", 32'(PENABLE), 1);
      check("ws_paddr", 32'(PADDR), 32'h00);
      check("ws_pwdata", 32'(PWDATA), 32'h3C);
      check("ws_level_held", 32'(fifo_level), 1);
      @(negedge PCLK);
    end
    check("ws_level_popped", 32'(fifo_level), 0);
    check("ws_psel_gap", 32'(PSEL), 0);
    wr_wait = 0;
    wait_drain(50);
    compare_writes("wait");
    repeat (8) @(negedge PCLK);

    // PSLVERR on a write: byte dropped, next byte still sent
    err_en = 1'b1; err_byte = 8'hA3;
    push_byte(8'hA3, acc);
    push_byte(8'h5C, acc);
    idle_in();
    wait_drain(100);
    compare_writes("error");
    check("error_err_cnt", 32'(err_cnt), ERR_CNT_ON ? 32'(exp_err) : 32'd0);
    err_en = 1'b0;
    repeat (8) @(negedge PCLK);

    // Asynchronous reset in the middle of a write
    wr_wait = 2;
    push_byte(8'hE0, acc);
    push_byte(8'hE1, acc);
    push_byte(8'hE2, acc);
    idle_in();
    wait_wr_access(50);
    #2;
    PRESETN = 1'b0;
    #1;
    check("arst_psel", 32'(PSEL), 0);
    check("arst_penable", 32'(PENABLE), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_err_cnt", 32'(err_cnt), 0);
    exp_q.delete();
    wr_q.delete();
    exp_err = 0;
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    wr_wait = 0;
    repeat (4) @(negedge PCLK);

    // Ordered stream under random waits and random tx_ready
    wr_wait = -1; poll_wait = -1; tx_mode = 2;
    for (int i = 0; i < 32; i++) begin
      int gap;
      gap = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) idle_in();
      stream_byte(8'(i));
    end
    idle_in();
    wait_drain(3000);
    compare_writes("order");
    check("order_err_cnt", 32'(err_cnt), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
